// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared definitions for the blocks that sit on the column side of the
//   systolic array.
//   - PSUM_DW_DEF / ACC_DW_DEF : default partial-sum and accumulator widths.
//   - state_e                  : collector FSM states (fixed legacy encoding).
//   - sat_add()                : signed add clamped to a w-bit signed range.
//                                Operands travel on a wide carrier so that one
//                                function serves any lane width up to SAT_W-1.
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int PSUM_DW_DEF = 20;
    localparam int ACC_DW_DEF  = 32;

    // Carrier width for sat_add operands and result.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Adds two sign-extended operands and clamps the result to the signed
    // range of a w-bit number. The caller truncates the result to w bits.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W:0] one;
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        one = {{SAT_W{1'b0}}, 1'b1};
        // One guard bit makes the carrier sum exact.
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (sum > hi) begin
            return hi[SAT_W-1:0];
        end else if (sum < lo) begin
            return lo[SAT_W-1:0];
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/systolic_psum_collector_if.sv
// -----------------------------------------------------------------------------
// systolic_psum_collector_if
//   Result-row handshake between the psum collector and the writeback stage.
//   - out_vld  : collector presents a finished row.
//   - out_rdy  : writeback accepts the row this cycle.
//   - out_data : COLS lanes of ACC_DW signed accumulators, lane c at
//                [c*ACC_DW +: ACC_DW].
//   Modports: master = collector side, slave = writeback side.
// -----------------------------------------------------------------------------
interface systolic_psum_collector_if #(
    parameter int COLS   = 8,
    parameter int ACC_DW = 32
);

    logic                   out_vld;
    logic                   out_rdy;
    logic [COLS*ACC_DW-1:0] out_data;

    modport master (
        output out_vld,
        output out_data,
        input  out_rdy
    );

    modport slave (
        input  out_vld,
        input  out_data,
        output out_rdy
    );

endinterface

// File: rtl/psum_deskew.sv
// -----------------------------------------------------------------------------
// psum_deskew
//   Removes the column skew of the bottom PE row. Lane c leaves the array c
//   cycles after lane 0, so lane c is delayed COLS-1-c cycles and the valid
//   (which is timed to lane 0) is delayed COLS-1 cycles. The last lane passes
//   straight through. Requires COLS >= 2.
//   Ports:
//   - clk, rst_n  : clock, asynchronous active-low reset (clears all stages).
//   - in_vld_i    : lane-0 partial sum valid.
//   - psum_i      : skewed lanes, lane c at [c*PSUM_DW +: PSUM_DW].
//   - al_vld_o    : aligned vector valid.
//   - al_psum_o   : aligned lanes, same packing as psum_i.
// -----------------------------------------------------------------------------
module psum_deskew #(
    parameter int COLS    = 8,
    parameter int PSUM_DW = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_vld_i,
    input  logic [COLS*PSUM_DW-1:0] psum_i,
    output logic                    al_vld_o,
    output logic [COLS*PSUM_DW-1:0] al_psum_o
);

    logic [COLS-2:0] vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int k = 1; k < COLS - 1; k++) begin
                vld_q[k] <= vld_q[k-1];
            end
        end
    end

    assign al_vld_o = vld_q[COLS-2];

    for (genvar c = 0; c < COLS; c++) begin : g_lane
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign al_psum_o[c*PSUM_DW +: PSUM_DW] = psum_i[c*PSUM_DW +: PSUM_DW];
        end else begin : g_dly
            logic [PSUM_DW-1:0] sr_q [D];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) begin
                        sr_q[k] <= '0;
                    end
                end else begin
                    sr_q[0] <= psum_i[c*PSUM_DW +: PSUM_DW];
                    for (int k = 1; k < D; k++) begin
                        sr_q[k] <= sr_q[k-1];
                    end
                end
            end

            assign al_psum_o[c*PSUM_DW +: PSUM_DW] = sr_q[D-1];
        end
    end

endmodule

// File: rtl/systolic_psum_collector.sv
// -----------------------------------------------------------------------------
// systolic_psum_collector
//   Collects the bottom-row partial sums of the systolic array, deskews them,
//   accumulates num_pass input-channel passes of num_rows rows into an on-chip
//   buffer with per-lane saturation, then drains the finished rows in order.
//   Ports:
//   - clk, rst_n : clock, asynchronous active-low reset.
//   - start      : job start pulse, honoured only in IDLE.
//   - num_pass   : passes to accumulate (1..255).
//   - num_rows   : rows per pass (1..DEPTH).
//   - in_vld     : lane-0 partial sum valid.
//   - psum_in    : skewed column partial sums, lane c at [c*PSUM_DW +: PSUM_DW].
//   - wb         : result row handshake (out_vld / out_rdy / out_data).
//   - busy       : job in progress (state not IDLE).
//   - done       : one-cycle pulse after the last row is accepted.
//   - err        : sticky error, cleared by an accepted start.
// -----------------------------------------------------------------------------
module systolic_psum_collector
    import systolic_pkg::*;
#(
    parameter int COLS    = 8,
    parameter int PSUM_DW = PSUM_DW_DEF,
    parameter int ACC_DW  = ACC_DW_DEF,
    parameter int DEPTH   = 64,
    parameter int ROW_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 num_pass,
    input  logic [ROW_W-1:0]           num_rows,
    input  logic                       in_vld,
    input  logic [COLS*PSUM_DW-1:0]    psum_in,
    systolic_psum_collector_if.master  wb,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ROW_BITS = COLS * ACC_DW;

    logic                    al_vld;
    logic [COLS*PSUM_DW-1:0] al_psum;

    psum_deskew #(
        .COLS    (COLS),
        .PSUM_DW (PSUM_DW)
    ) u_deskew (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (in_vld),
        .psum_i    (psum_in),
        .al_vld_o  (al_vld),
        .al_psum_o (al_psum)
    );

    state_e              state_q, state_d;
    logic [7:0]          num_pass_q, num_pass_d;
    logic [7:0]          pass_cnt_q, pass_cnt_d;
    logic [ROW_W-1:0]    num_rows_q, num_rows_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic                out_vld_q, out_vld_d;
    logic [ROW_BITS-1:0] out_data_q, out_data_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Accumulation buffer: contents are only meaningful after the pass-0
    // writes of the current job, so it carries no reset.
    logic [ROW_BITS-1:0] acc_q [DEPTH];
    logic [ROW_BITS-1:0] acc_rd;
    logic [ROW_BITS-1:0] acc_wr;
    logic [ROW_BITS-1:0] drn_rd;
    logic                acc_we;
    logic [IDX_W-1:0]    row_idx;
    logic [IDX_W-1:0]    drn_idx;
    logic                last_row;
    logic                last_pass;

    logic signed [PSUM_DW-1:0] lane_p;
    logic signed [ACC_DW-1:0]  lane_a;
    logic signed [ACC_DW-1:0]  lane_s;

    assign row_idx   = row_cnt_q[IDX_W-1:0];
    assign last_row  = (row_cnt_q == num_rows_q - ROW_W'(1));
    assign last_pass = (pass_cnt_q == num_pass_q - 8'd1);

    // In DRAIN the output register is refilled with the row after the one
    // being handed over, so the read address runs one ahead on a handshake.
    assign drn_idx = (out_vld_q && wb.out_rdy) ? row_idx + IDX_W'(1) : row_idx;

    // The read-modify-write completes in a single cycle, so a row written on
    // one edge is already visible to the read on the next cycle; this gives
    // the num_rows==1 case its forwarding without a separate bypass path.
    assign acc_rd = acc_q[row_idx];
    assign drn_rd = acc_q[drn_idx];

    always_comb begin
        acc_wr = '0;
        lane_p = '0;
        lane_a = '0;
        lane_s = '0;
        for (int c = 0; c < COLS; c++) begin
            lane_p = al_psum[c*PSUM_DW +: PSUM_DW];
            lane_a = acc_rd[c*ACC_DW +: ACC_DW];
            if (pass_cnt_q == 8'd0) begin
                lane_s = ACC_DW'(lane_p);
            end else begin
                lane_s = ACC_DW'(sat_add(SAT_W'(lane_a), SAT_W'(lane_p), ACC_DW));
            end
            acc_wr[c*ACC_DW +: ACC_DW] = lane_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        num_pass_d = num_pass_q;
        num_rows_d = num_rows_q;
        pass_cnt_d = pass_cnt_q;
        row_cnt_d  = row_cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        err_d      = err_q;
        acc_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((num_pass == 8'd0) || (num_rows == '0) ||
                        (num_rows > ROW_W'(DEPTH))) begin
                        err_d = 1'b1;
                    end else begin
                        num_pass_d = num_pass;
                        num_rows_d = num_rows;
                        pass_cnt_d = '0;
                        row_cnt_d  = '0;
                        err_d      = 1'b0;
                        state_d    = ST_ACCUM;
                    end
                end
            end

            ST_ACCUM: begin
                if (al_vld) begin
                    acc_we = 1'b1;
                    if (last_row) begin
                        row_cnt_d  = '0;
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        if (last_pass) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // row_cnt_q is the row currently held in the output register.
                if (!out_vld_q) begin
                    out_vld_d  = 1'b1;
                    out_data_d = drn_rd;
                end else if (wb.out_rdy) begin
                    if (last_row) begin
                        out_vld_d = 1'b0;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        row_cnt_d  = row_cnt_q + ROW_W'(1);
                        out_data_d = drn_rd;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Misplaced data and start pulses are flagged, never acted on.
        if (al_vld && (state_q != ST_ACCUM)) begin
            err_d = 1'b1;
        end
        if (start && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            num_pass_q <= '0;
            num_rows_q <= '0;
            pass_cnt_q <= '0;
            row_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_pass_q <= num_pass_d;
            num_rows_q <= num_rows_d;
            pass_cnt_q <= pass_cnt_d;
            row_cnt_q  <= row_cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_we) begin
            acc_q[row_idx] <= acc_wr;
        end
    end

    assign wb.out_vld  = out_vld_q;
    assign wb.out_data = out_data_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_systolic_psum_collector.sv
// -----------------------------------------------------------------------------
// tb_systolic_psum_collector
//   Self-checking bench for systolic_psum_collector (COLS=8, PSUM_DW=20,
//   ACC_DW=24, DEPTH=64). Constant-data jobs come from a vector table with
//   hand-computed lane results; random jobs are checked against a reference
//   that sums each row's passes in plain integer arithmetic with clamping.
// -----------------------------------------------------------------------------
module tb_systolic_psum_collector;

    localparam int COLS    = 8;
    localparam int PSUM_DW = 20;
    localparam int ACC_DW  = 24;
    localparam int DEPTH   = 64;
    localparam int ROW_W   = $clog2(DEPTH + 1);
    localparam int OW      = COLS * ACC_DW;
    localparam longint MAXV = (longint'(1) <<< (ACC_DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_DW - 1));

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    start;
    logic [7:0]              num_pass;
    logic [ROW_W-1:0]        num_rows;
    logic                    in_vld;
    logic [COLS*PSUM_DW-1:0] psum_in;
    logic                    busy;
    logic                    done;
    logic                    err;

    systolic_psum_collector_if #(.COLS(COLS), .ACC_DW(ACC_DW)) wb_if ();

    systolic_psum_collector #(
        .COLS    (COLS),
        .PSUM_DW (PSUM_DW),
        .ACC_DW  (ACC_DW),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .num_pass (num_pass),
        .num_rows (num_rows),
        .in_vld   (in_vld),
        .psum_in  (psum_in),
        .wb       (wb_if.master),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int            stim_v   [512][COLS];
    logic [OW-1:0] exp_rows [DEPTH];

    typedef struct {
        int np;
        int nr;
        int val;
        int lane_exp;
        int rdy_mode;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int np, input int nr);
        cycle();
        start    = 1'b1;
        num_pass = np[7:0];
        num_rows = nr[ROW_W-1:0];
        cycle();
        start    = 1'b0;
    endtask

    task automatic fill_random(input int nitems, input int lo, input int span);
        for (int k = 0; k < nitems; k++) begin
            for (int c = 0; c < COLS; c++) begin
                stim_v[k][c] = lo + int'($urandom_range(0, span - 1));
            end
        end
    endtask

    // Reference: each output lane is the clamped running sum of that row's
    // lane values over all passes; item index = pass * num_rows + row.
    function automatic void model(input int np, input int nr);
        longint a;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a = stim_v[r][c];
                for (int p = 1; p < np; p++) begin
                    a = a + stim_v[p*nr + r][c];
                    if (a > MAXV) a = MAXV;
                    if (a < MINV) a = MINV;
                end
                exp_rows[r][c*ACC_DW +: ACC_DW] = a[ACC_DW-1:0];
            end
        end
    endfunction

    // Items are placed in time slots (with random idle slots); lane c shows
    // the item of slot i-c at cycle i, reproducing the array's column skew.
    task automatic drive_stream(input int nitems, input int gap_pct);
        int slot[$];
        int len;
        int j;
        for (int k = 0; k < nitems; k++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) slot.push_back(-1);
            slot.push_back(k);
        end
        len = slot.size();
        for (int i = 0; i < len + COLS - 1; i++) begin
            in_vld = (i < len) && (slot[i] >= 0);
            for (int c = 0; c < COLS; c++) begin
                j = i - c;
                if (j >= 0 && j < len && slot[j] >= 0) begin
                    psum_in[c*PSUM_DW +: PSUM_DW] = stim_v[slot[j]][c][PSUM_DW-1:0];
                end else begin
                    psum_in[c*PSUM_DW +: PSUM_DW] = PSUM_DW'($urandom);
                end
            end
            cycle();
        end
        in_vld = 1'b0;
    endtask

    // rdy_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
    task automatic drain(input int nrows, input int rdy_mode);
        int            got = 0;
        int            cyc = 0;
        int            pi  = 0;
        bit            stalled = 0;
        bit            pat [4];
        logic [OW-1:0] held = '0;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        while (got < nrows && cyc < 2000) begin
            cycle();
            if (rdy_mode == 0)      wb_if.out_rdy = 1'b1;
            else if (rdy_mode == 1) wb_if.out_rdy = pat[pi % 4];
            else                    wb_if.out_rdy = 1'($urandom_range(0, 1));
            pi++;
            #3;
            if (stalled) begin
                check($sformatf("hold_vld_r%0d", got), OW'(wb_if.out_vld), OW'(1'b1));
                check($sformatf("hold_data_r%0d", got), wb_if.out_data, held);
            end
            if (wb_if.out_vld && wb_if.out_rdy) begin
                check($sformatf("row%0d", got), wb_if.out_data, exp_rows[got]);
                got++;
                stalled = 0;
            end else if (wb_if.out_vld) begin
                stalled = 1;
                held    = wb_if.out_data;
            end else begin
                stalled = 0;
            end
            cyc++;
        end
        if (got < nrows) begin
            check("drain_timeout_rows", OW'(got), OW'(nrows));
        end
        cycle();
        wb_if.out_rdy = 1'b0;
        check("done_pulse", OW'(done), OW'(1'b1));
        check("busy_low_at_done", OW'(busy), OW'(1'b0));
        cycle();
        check("done_clear", OW'(done), OW'(1'b0));
    endtask

    task automatic run_job(input int np, input int nr, input int gap, input int rdy_mode);
        start_job(np, nr);
        drive_stream(np * nr, gap);
        drain(nr, rdy_mode);
    endtask

    task automatic wait_out_vld(input int budget, output bit ok);
        int i = 0;
        ok = 0;
        while (!ok && i < budget) begin
            if (wb_if.out_vld) ok = 1;
            else begin
                cycle();
                i++;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_vld"}, OW'(wb_if.out_vld), '0);
        check({tag, "_out_data"}, wb_if.out_data, '0);
        check({tag, "_busy"}, OW'(busy), '0);
        check({tag, "_done"}, OW'(done), '0);
        check({tag, "_err"}, OW'(err), '0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int np;
        int nr;
        int ev;

        rst_n         = 1'b0;
        start         = 1'b0;
        num_pass      = '0;
        num_rows      = '0;
        in_vld        = 1'b0;
        psum_in       = '0;
        wb_if.out_rdy = 1'b0;

        tbl[0] = '{np: 3,   nr: 2, val: -5,      lane_exp: -15,      rdy_mode: 0};
        tbl[1] = '{np: 1,   nr: 5, val: 123456,  lane_exp: 123456,   rdy_mode: 2};
        tbl[2] = '{np: 255, nr: 1, val: 524287,  lane_exp: 8388607,  rdy_mode: 0};
        tbl[3] = '{np: 255, nr: 1, val: -524288, lane_exp: -8388608, rdy_mode: 0};
        tbl[4] = '{np: 4,   nr: 3, val: 1000,    lane_exp: 4000,     rdy_mode: 2};
        tbl[5] = '{np: 2,   nr: 2, val: -524288, lane_exp: -1048576, rdy_mode: 1};

        repeat (3) cycle();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        cycle();

        // Deskew, single pass: lane c of row r carries r*10+c.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < COLS; c++) begin
                stim_v[r][c] = r * 10 + c;
                exp_rows[r][c*ACC_DW +: ACC_DW] = ACC_DW'(r * 10 + c);
            end
        end
        run_job(1, 4, 0, 0);

        // Constant-data table: multi-pass, saturation both ways, stalls.
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].np * tbl[i].nr; k++) begin
                for (int c = 0; c < COLS; c++) stim_v[k][c] = tbl[i].val;
            end
            ev = tbl[i].lane_exp;
            for (int r = 0; r < tbl[i].nr; r++) begin
                for (int c = 0; c < COLS; c++) exp_rows[r][c*ACC_DW +: ACC_DW] = ev[ACC_DW-1:0];
            end
            run_job(tbl[i].np, tbl[i].nr, (i == 1) ? 30 : 0, tbl[i].rdy_mode);
        end

        // Backpressure 1,0,0,1 on random data.
        fill_random(10, -524288, 1048576);
        model(2, 5);
        run_job(2, 5, 20, 1);

        // Bad job parameters.
        start_job(1, 0);
        check("err_rows0", OW'(err), OW'(1'b1));
        check("busy_rows0", OW'(busy), OW'(1'b0));
        start_job(0, 3);
        check("err_pass0", OW'(err), OW'(1'b1));
        check("busy_pass0", OW'(busy), OW'(1'b0));
        start_job(2, 65);
        check("err_rows65", OW'(err), OW'(1'b1));
        check("busy_rows65", OW'(busy), OW'(1'b0));

        // Accepted start clears err; start while busy and data in DRAIN set it.
        fill_random(6, -524288, 1048576);
        model(2, 3);
        start_job(2, 3);
        check("err_cleared", OW'(err), OW'(1'b0));
        check("busy_job", OW'(busy), OW'(1'b1));
        start    = 1'b1;
        num_pass = 8'd9;
        num_rows = ROW_W'(7);
        cycle();
        start = 1'b0;
        check("err_start_busy", OW'(err), OW'(1'b1));
        check("busy_after_restart", OW'(busy), OW'(1'b1));
        drive_stream(6, 0);
        wait_out_vld(200, ok);
        check("drain_entry", OW'(ok), OW'(1'b1));
        in_vld  = 1'b1;
        psum_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
        cycle();
        in_vld = 1'b0;
        repeat (COLS + 2) cycle();
        check("err_vld_drain", OW'(err), OW'(1'b1));
        check("busy_vld_drain", OW'(busy), OW'(1'b1));
        drain(3, 0);

        // Random jobs against the reference.
        for (int j = 0; j < 6; j++) begin
            np = int'($urandom_range(1, 6));
            nr = int'($urandom_range(1, 16));
            fill_random(np * nr, -524288, 1048576);
            model(np, nr);
            run_job(np, nr, 30, 2);
        end
        fill_random(120, 400000, 124288);
        model(40, 3);
        run_job(40, 3, 10, 2);

        // Asynchronous reset in the middle of accumulation.
        fill_random(12, -524288, 1048576);
        start_job(3, 4);
        start    = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_vld  = 1'b1;
            psum_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
            cycle();
        end
        #2;
        rst_n  = 1'b0;
        in_vld = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cycle();
        rst_n = 1'b1;
        model(3, 4);
        run_job(3, 4, 20, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
